// File: rtl/sequential_divider.sv
// Signed restoring sequential divider: one quotient bit per clock, then sign correction.
// Results and flags are registered and announced with a one-cycle ready pulse.
module sequential_divider #(
  parameter int unsigned Length = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [Length-1:0] dividend_i,
  input  logic [Length-1:0] divisor_i,
  output logic [Length-1:0] quotient_o,
  output logic [Length-1:0] remainder_o,
  output logic              computing_o,
  output logic              ready_o,
  output logic              negative_o,
  output logic              overflow_o,
  output logic              div_by_zero_o
);

  localparam int unsigned CntW = $clog2(Length + 1);
  localparam logic [Length-1:0] MinMag = {1'b1, {(Length-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StDivide, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic              start_prev_q;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [Length-1:0] mag_b_q, mag_b_d;
  logic [Length:0]   rem_q, rem_d;
  logic [Length-1:0] quo_q, quo_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Length-1:0] quotient_q, quotient_d;
  logic [Length-1:0] remainder_q, remainder_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              dbz_q, dbz_d;
  logic              computing_q, computing_d;
  logic              ready_q, ready_d;

  logic              start_edge;
  logic              sign_diff;
  logic [Length+1:0] rem_shift;
  logic [Length+1:0] rem_diff;
  logic              rem_ge;

  assign start_edge = start_i & ~start_prev_q;
  assign sign_diff  = sign_a_q ^ sign_b_q;

  // Trial subtraction one bit wider than the remainder; the borrow decides the quotient bit.
  assign rem_shift = {rem_q, quo_q[Length-1]};
  assign rem_diff  = rem_shift - {2'b00, mag_b_q};
  assign rem_ge    = ~rem_diff[Length+1];

  always_comb begin
    state_d     = state_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    mag_b_d     = mag_b_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    ready_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          if (divisor_i == '0) begin
            quotient_d  = '1;
            remainder_d = dividend_i;
            dbz_d       = 1'b1;
            neg_d       = 1'b0;
            ovf_d       = 1'b0;
            ready_d     = 1'b1;
            state_d     = StDone;
          end else begin
            sign_a_d = dividend_i[Length-1];
            sign_b_d = divisor_i[Length-1];
            mag_b_d  = divisor_i[Length-1] ? -divisor_i : divisor_i;
            quo_d    = dividend_i[Length-1] ? -dividend_i : dividend_i;
            rem_d    = '0;
            cnt_d    = CntW'(Length);
            state_d  = StDivide;
          end
        end
      end
      StDivide: begin
        rem_d = rem_ge ? rem_diff[Length:0] : rem_shift[Length:0];
        quo_d = {quo_q[Length-2:0], rem_ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        quotient_d  = sign_diff ? -quo_q : quo_q;
        remainder_d = sign_a_q ? -rem_q[Length-1:0] : rem_q[Length-1:0];
        // Only +2^(Length-1) is unrepresentable; it wraps to the most negative code.
        ovf_d       = ~sign_diff && (quo_q == MinMag);
        neg_d       = sign_diff && (quo_q != '0);
        dbz_d       = 1'b0;
        ready_d     = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    computing_d = (state_d == StDivide) || (state_d == StFix);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b1;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      mag_b_q      <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
      dbz_q        <= 1'b0;
      computing_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_i;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      mag_b_q      <= mag_b_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
      neg_q        <= neg_d;
      ovf_q        <= ovf_d;
      dbz_q        <= dbz_d;
      computing_q  <= computing_d;
      ready_q      <= ready_d;
    end
  end

  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign computing_o   = computing_q;
  assign ready_o       = ready_q;
  assign negative_o    = neg_q;
  assign overflow_o    = ovf_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider (Length = 5) with hand-computed results.
module tb_sequential_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] dividend;
  logic [4:0] divisor;
  logic [4:0] quotient;
  logic [4:0] remainder;
  logic       computing;
  logic       ready;
  logic       negative;
  logic       overflow;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_cnt = 0;
  int overlap_cnt = 0;

  sequential_divider #(.Length(5)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .computing_o  (computing),
    .ready_o      (ready),
    .negative_o   (negative),
    .overflow_o   (overflow),
    .div_by_zero_o(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ready cycles and ready/computing overlap using pre-edge values.
  always @(posedge clk) begin
    if (ready === 1'b1) ready_cnt++;
    if (ready === 1'b1 && computing === 1'b1) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] eq, input logic [4:0] er,
                            input logic en, input logic eo, input logic ez);
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " negative"}, 32'(negative), 32'(en));
    check({tag, " overflow"}, 32'(overflow), 32'(eo));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
  endtask

  // One start pulse; k counts negedges after the sampling edge T0.
  task automatic do_div(input string tag, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] eq, input logic [4:0] er,
                        input logic en, input logic eo, input logic ez);
    int first;
    int base;
    bit comp_seen;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    base      = ready_cnt;
    first     = -1;
    comp_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (ready === 1'b1 && first < 0) first = k;
      if (computing === 1'b1) comp_seen = 1'b1;
    end
    check({tag, " latency"}, 32'(first), (b == 5'd0) ? 32'd0 : 32'd6);
    check({tag, " pulses"}, 32'(ready_cnt - base), 32'd1);
    check({tag, " computing"}, 32'(comp_seen), (b == 5'd0) ? 32'd0 : 32'd1);
    check_outs(tag, eq, er, en, eo, ez);
  endtask

  initial begin
    int base;
    bit comp_seen;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("reset computing", 32'(computing), 32'd0);
    check("reset ready", 32'(ready), 32'd0);
    check_outs("reset", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_div("13/4", 5'd13, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0, 1'b0);
    do_div("-13/4", 5'b10011, 5'd4, 5'b11101, 5'b11111, 1'b1, 1'b0, 1'b0);
    do_div("13/-4", 5'd13, 5'b11100, 5'b11101, 5'd1, 1'b1, 1'b0, 1'b0);
    do_div("-16/-1", 5'b10000, 5'b11111, 5'b10000, 5'd0, 1'b0, 1'b1, 1'b0);
    do_div("-16/1", 5'b10000, 5'd1, 5'b10000, 5'd0, 1'b1, 1'b0, 1'b0);
    do_div("7/0", 5'd7, 5'd0, 5'b11111, 5'b00111, 1'b0, 1'b0, 1'b1);
    do_div("0/-5", 5'd0, 5'b11011, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    do_div("15/-16", 5'd15, 5'b10000, 5'd0, 5'd15, 1'b0, 1'b0, 1'b0);

    // Start held high for 20 cycles: one result only; operands change after T0.
    @(negedge clk);
    dividend = 5'd9;
    divisor  = 5'd2;
    start    = 1'b1;
    base     = ready_cnt;
    @(negedge clk);
    dividend = 5'b11111;
    divisor  = 5'd0;
    repeat (19) @(negedge clk);
    check("hold pulses", 32'(ready_cnt - base), 32'd1);
    check_outs("hold 9/2", 5'd4, 5'd1, 1'b0, 1'b0, 1'b0);
    start = 1'b0;

    // Second start edge while dividing is ignored.
    @(negedge clk);
    dividend = 5'b11001;
    divisor  = 5'd2;
    start    = 1'b1;
    base     = ready_cnt;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 5'd3;
    divisor  = 5'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("mid-divide pulses", 32'(ready_cnt - base), 32'd1);
    check_outs("-7/2", 5'b11101, 5'b11111, 1'b1, 1'b0, 1'b0);

    do_div("re-press 10/3", 5'd10, 5'd3, 5'd3, 5'd1, 1'b0, 1'b0, 1'b0);

    // Start edge sampled while in DONE is lost.
    @(negedge clk);
    dividend = 5'd13;
    divisor  = 5'd4;
    start    = 1'b1;
    base     = ready_cnt;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("done ready", 32'(ready), 32'd1);
    dividend = 5'd1;
    divisor  = 5'd1;
    start    = 1'b1;
    repeat (12) @(negedge clk);
    check("done lost pulses", 32'(ready_cnt - base), 32'd1);
    check_outs("done lost", 5'd3, 5'd1, 1'b0, 1'b0, 1'b0);
    start = 1'b0;

    // Asynchronous reset in DIVIDE, start held across release.
    @(negedge clk);
    dividend = 5'd15;
    divisor  = 5'd3;
    start    = 1'b1;
    base     = ready_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset computing", 32'(computing), 32'd0);
    check("mid reset ready", 32'(ready), 32'd0);
    check_outs("mid reset", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    comp_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (computing === 1'b1) comp_seen = 1'b1;
    end
    check("post reset pulses", 32'(ready_cnt - base), 32'd0);
    check("post reset computing", 32'(comp_seen), 32'd0);
    start = 1'b0;

    do_div("-9/4", 5'b10111, 5'd4, 5'b11110, 5'b11111, 1'b1, 1'b0, 1'b0);

    check("ready/computing overlap", 32'(overlap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
